mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator_if.sv | 37 +++
 rtl/mac_accumulator.sv | 155 +++++++++++++++
 tb/tb_mac_accumulator.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accumulator_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mac_accumulator_if
// Description : Data-path handshake bundle between MAC array, accumulator and
//               result consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_accumulator_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] res_mac_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output res_mac_n,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  res_mac_n,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mac_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mac_accumulator
// Description : Saturating multi-lane accumulator for packed MAC results
//               (8x8b, 4x16b, 2x32b or 1x64b), with IDLE/ACCUM/DRAIN control.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_accumulator #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 8
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 enable,
    input  wire logic [3:0]           select_precision,
    input  wire logic [CNT_WIDTH-1:0] acc_len,
    input  wire logic                 start,
    mac_accumulator_if.slave          bus,
    output logic                      sat_flag,
    output logic                      busy,
    output logic                      prec_err
);

    localparam int NUM_FMT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0]  acc_q;
    logic [1:0]             prec_q;
    logic                   sat_q;
    logic                   busy_q;
    logic                   out_valid_q;
    logic                   prec_err_q;

    logic                   prec_legal;
    logic [1:0]             prec_idx;
    logic [CNT_WIDTH-1:0]   len_d;
    logic [DATA_WIDTH-1:0]  acc_d;
    logic                   ovf_d;
    logic                   beat_acc;

    logic [DATA_WIDTH-1:0]  fmt_sum [NUM_FMT];
    logic [NUM_FMT-1:0]     fmt_ovf;

    // Every lane format is evaluated in parallel; the latched format picks one.
    for (genvar k = 0; k < NUM_FMT; k++) begin : g_fmt
        localparam int LW = 8 << k;
        localparam int NL = DATA_WIDTH / LW;

        logic [DATA_WIDTH-1:0] sum;
        logic [NL-1:0]         ovf;

        for (genvar l = 0; l < NL; l++) begin : g_lane
            logic [LW-1:0] a;
            logic [LW-1:0] b;
            logic [LW-1:0] s;

            assign a      = acc_q[l*LW +: LW];
            assign b      = bus.res_mac_n[l*LW +: LW];
            assign s      = a + b;
            assign ovf[l] = (a[LW-1] == b[LW-1]) && (s[LW-1] != a[LW-1]);
            // Clamp toward the operands' common sign: 0x80.. or 0x7F..
            assign sum[l*LW +: LW] = ovf[l] ? {a[LW-1], {(LW-1){~a[LW-1]}}} : s;
        end

        assign fmt_sum[k] = sum;
        assign fmt_ovf[k] = |ovf;
    end

    always_comb begin
        prec_legal = 1'b1;
        prec_idx   = 2'd0;
        case (select_precision)
            4'h1:    prec_idx = 2'd0;
            4'h3:    prec_idx = 2'd1;
            4'h7:    prec_idx = 2'd2;
            4'hF:    prec_idx = 2'd3;
            default: prec_legal = 1'b0;
        endcase
    end

    assign len_d    = (acc_len == '0) ? CNT_WIDTH'(1) : acc_len;
    assign acc_d    = fmt_sum[prec_q];
    assign ovf_d    = fmt_ovf[prec_q];
    assign beat_acc = (state_q == S_ACCUM) && enable && bus.in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            prec_q      <= 2'd0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            prec_err_q  <= 1'b0;
        end else begin
            prec_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && enable) begin
                        if (prec_legal) begin
                            state_q <= S_ACCUM;
                            acc_q   <= '0;
                            sat_q   <= 1'b0;
                            prec_q  <= prec_idx;
                            cnt_q   <= len_d;
                            busy_q  <= 1'b1;
                        end else begin
                            prec_err_q <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (beat_acc) begin
                        acc_q <= acc_d;
                        sat_q <= sat_q | ovf_d;
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                        if (cnt_q == CNT_WIDTH'(1)) begin
                            state_q     <= S_DRAIN;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // in_ready must track enable within the same cycle, so it is a decode.
    assign bus.in_ready  = (state_q == S_ACCUM) && enable;
    assign bus.out_data  = acc_q;
    assign bus.out_valid = out_valid_q;
    assign sat_flag      = sat_q;
    assign busy          = busy_q;
    assign prec_err      = prec_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mac_accumulator
// Description : Directed-vector bench for mac_accumulator with a lane-level
//               reference model and per-cycle output comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       enable;
    logic [3:0] select_precision;
    logic [7:0] acc_len;
    logic       start;
    logic       sat_flag;
    logic       busy;
    logic       prec_err;

    mac_accumulator_if #(.DATA_WIDTH(64)) bus ();

    mac_accumulator #(.DATA_WIDTH(64), .CNT_WIDTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .select_precision (select_precision),
        .acc_len          (acc_len),
        .start            (start),
        .bus              (bus),
        .sat_flag         (sat_flag),
        .busy             (busy),
        .prec_err         (prec_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_ph   = 0;   // 0 idle, 1 accumulating, 2 result pending
    int          m_lw   = 8;
    int          m_cnt  = 0;
    logic [63:0] m_acc  = '0;
    bit          m_sat  = 1'b0;
    bit          m_perr = 1'b0;

    logic [63:0] t_mask, t_lane, t_in, t_res, t_nxt;
    bit          t_o;
    int          t_lw;

    function automatic logic [63:0] sadd(input logic [63:0] a, input logic [63:0] b,
                                         input int w, output bit ovf);
        logic        [65:0] m;
        logic signed [65:0] sa, sb, s, mx, mn;
        m  = (66'd1 << w) - 66'd1;
        sa = {2'b00, a} & m;
        sb = {2'b00, b} & m;
        if (sa[w-1]) sa = sa | ~m;
        if (sb[w-1]) sb = sb | ~m;
        s   = sa + sb;
        mx  = $signed(m >> 1);
        mn  = ~mx;
        ovf = 1'b0;
        if (s > mx) begin s = mx; ovf = 1'b1; end
        else if (s < mn) begin s = mn; ovf = 1'b1; end
        return s[63:0] & m[63:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph = 0; m_cnt = 0; m_acc = '0; m_sat = 1'b0; m_perr = 1'b0;
        end else begin
            m_perr = 1'b0;
            case (m_ph)
                0: if (start && enable) begin
                    case (select_precision)
                        4'h1: t_lw = 8;
                        4'h3: t_lw = 16;
                        4'h7: t_lw = 32;
                        4'hF: t_lw = 64;
                        default: t_lw = 0;
                    endcase
                    if (t_lw != 0) begin
                        m_ph = 1; m_lw = t_lw; m_acc = '0; m_sat = 1'b0;
                        m_cnt = (acc_len == 0) ? 1 : int'(acc_len);
                    end else begin
                        m_perr = 1'b1;
                    end
                end
                1: if (bus.in_valid && enable) begin
                    t_mask = (m_lw == 64) ? '1 : ((64'd1 << m_lw) - 64'd1);
                    t_nxt  = '0;
                    for (int l = 0; l < 64 / m_lw; l++) begin
                        t_lane = (m_acc >> (l * m_lw)) & t_mask;
                        t_in   = (bus.res_mac_n >> (l * m_lw)) & t_mask;
                        t_res  = sadd(t_lane, t_in, m_lw, t_o);
                        t_nxt  = t_nxt | (t_res << (l * m_lw));
                        m_sat  = m_sat | t_o;
                    end
                    m_acc = t_nxt;
                    m_cnt--;
                    if (m_cnt == 0) m_ph = 2;
                end
                2: if (bus.out_ready) m_ph = 0;
                default: m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy",      busy,          64'(m_ph != 0));
        chk("in_ready",  bus.in_ready,  64'((m_ph == 1) && enable));
        chk("out_valid", bus.out_valid, 64'(m_ph == 2));
        chk("prec_err",  prec_err,      64'(m_perr));
        if (m_ph == 2 || reset) begin
            chk("out_data", bus.out_data, m_acc);
            chk("sat_flag", sat_flag,     64'(m_sat));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic job(input logic [3:0] p, input logic [7:0] len);
        select_precision = p;
        acc_len          = len;
        start            = 1'b1;
        tick();
        start            = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d);
        bus.res_mac_n = d;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_valid"}, bus.out_valid, 64'd1);
    endtask

    task automatic drain;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("drain_busy", busy, 64'd0);
    endtask

    initial begin
        enable           = 1'b0;
        select_precision = 4'h1;
        acc_len          = 8'd1;
        start            = 1'b0;
        bus.res_mac_n    = '0;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;

        #1 reset = 1'b1;
        #1;
        chk("rst_out_data",  bus.out_data,  64'd0);
        chk("rst_out_valid", bus.out_valid, 64'd0);
        chk("rst_busy",      busy,          64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        enable = 1'b1;
        tick();

        // 16-bit, two beats, exact one-cycle latency
        job(4'h3, 8'd2);
        beat(64'h0001_0002_0003_0004);
        chk("r038_early_valid", bus.out_valid, 64'd0);
        beat(64'h0001_0002_0003_0004);
        chk("r038_valid", bus.out_valid, 64'd1);
        chk("r038_data",  bus.out_data,  64'h0002_0004_0006_0008);
        chk("r038_sat",   sat_flag,      64'd0);
        drain();

        // 8-bit saturation
        job(4'h1, 8'd3);
        repeat (3) beat({4{16'hCAFE}});
        wait_out("r037");
        chk("r037_data", bus.out_data, {4{16'h80FA}});
        chk("r037_sat",  sat_flag,     64'd1);
        drain();

        // 64-bit positive saturation
        job(4'hF, 8'd2);
        repeat (2) beat(64'h4000_0000_0000_0000);
        wait_out("r039");
        chk("r039_data", bus.out_data, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("r039_sat",  sat_flag,     64'd1);
        drain();

        // back-pressure hold with start and in_valid pulsed during DRAIN
        job(4'h3, 8'd1);
        beat(64'h1234_5678_9ABC_DEF0);
        for (int i = 0; i < 5; i++) begin
            start        = (i == 2);
            bus.in_valid = (i == 3);
            tick();
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
        chk("r040_valid",    bus.out_valid, 64'd1);
        chk("r040_data",     bus.out_data,  64'h1234_5678_9ABC_DEF0);
        chk("r040_in_ready", bus.in_ready,  64'd0);
        drain();
        chk("r040_idle_valid", bus.out_valid, 64'd0);

        // illegal precision
        select_precision = 4'h2;
        start            = 1'b1;
        tick();
        start            = 1'b0;
        chk("r041_perr",     prec_err,     64'd1);
        chk("r041_busy",     busy,         64'd0);
        chk("r041_in_ready", bus.in_ready, 64'd0);
        tick();
        chk("r041_perr_off", prec_err,     64'd0);

        // start ignored while enable is low
        enable = 1'b0;
        job(4'h3, 8'd1);
        chk("en0_busy", busy, 64'd0);
        enable = 1'b1;

        // acc_len=0 acts as one beat; enable low stalls acceptance
        job(4'h3, 8'd0);
        enable        = 1'b0;
        bus.res_mac_n = 64'h0005_FFFF_0007_8000;
        bus.in_valid  = 1'b1;
        tick();
        tick();
        chk("stall_valid", bus.out_valid, 64'd0);
        enable = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("len0_valid", bus.out_valid, 64'd1);
        chk("len0_data",  bus.out_data,  64'h0005_FFFF_0007_8000);
        drain();

        // 32-bit negative clamp; mid-job precision/length changes ignored
        job(4'h7, 8'd2);
        select_precision = 4'h1;
        acc_len          = 8'd5;
        repeat (2) beat(64'h8000_0001_7FFF_FFFF);
        wait_out("r032");
        chk("r032_data", bus.out_data, 64'h8000_0000_7FFF_FFFF);
        chk("r032_sat",  sat_flag,     64'd1);
        drain();

        // asynchronous reset mid-job
        job(4'h3, 8'd3);
        beat(64'h1111_2222_3333_4444);
        #1 reset = 1'b1;
        #1;
        chk("r042_busy",      busy,          64'd0);
        chk("r042_in_ready",  bus.in_ready,  64'd0);
        chk("r042_out_valid", bus.out_valid, 64'd0);
        chk("r042_out_data",  bus.out_data,  64'd0);
        chk("r042_sat",       sat_flag,      64'd0);
        chk("r042_perr",      prec_err,      64'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        job(4'h3, 8'd1);
        beat(64'h7FFF_8000_0001_FFFF);
        wait_out("r042b");
        chk("r042b_data", bus.out_data, 64'h7FFF_8000_0001_FFFF);
        chk("r042b_sat",  sat_flag,     64'd0);
        drain();

        // back-to-back: next job started the cycle right after the handshake
        job(4'h1, 8'd1);
        beat(64'h0102_0304_0506_0708);
        wait_out("b2b");
        chk("b2b_data", bus.out_data, 64'h0102_0304_0506_0708);
        drain();

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
